cube: RTL and testbench
=======================

Name: cube

Overview:
- Iterative integer cube: computes y = a^3 for an unsigned WIDTH-bit operand. It is the inverse companion to the integer cube-root block.
- Follows the same shared-adder discipline: every wide addition goes through an external 16-bit adder via sum_in_a/sum_in_b/sum_out. The only local arithmetic is the small bit counter.
- Sits beside the root block on the same adder mux. A top level can verify root results (cube(r) <= x < cube(r+1)).

Parameters:
- WIDTH, 5, operand width in bits. Legal range 1..5, so (2^WIDTH-1)^3 fits in 16 bits. Enforce with an elaboration-time check.
- RES_W, 16, result width in bits. Fixed to the shared adder width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- a_i  input  WIDTH  operand, sampled only in the cycle start is accepted.
- start  input  1  request pulse or level. Accepted only in IDLE.
- result  output  16  a_i^3. Valid when busy is low after a run.
- busy  output  1  high from the cycle after start is accepted until the result is written.
- sum_in_a  output  16  shared adder operand A.
- sum_in_b  output  16  shared adder operand B.
- sum_out  input  16  shared adder sum, combinational (sum_in_a + sum_in_b) mod 2^16.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; result=0, busy=0, sum_in_a=0, sum_in_b=0.
  - Internal registers a, acc, mcand and cnt are all cleared.
  - Reset mid-run aborts immediately. There is no partial result write.
- Registers:
  - a: WIDTH bits, the multiplier.
  - mcand: 16 bits, the multiplicand.
  - acc: 16 bits, the accumulator.
  - cnt: ceil(log2(WIDTH))+1 bits, the bit index.
- States: IDLE, P1, XFER, P2. busy = (state != IDLE), decoded combinationally.
- IDLE:
  - sum_in_a = sum_in_b = 0.
  - If start: a <= a_i; mcand <= zero-extended a_i; acc <= 0; cnt <= 0; go to P1.
- P1 (a*a), one bit per cycle:
  - sum_in_a = acc.
  - sum_in_b = a[cnt] ? (mcand << cnt) truncated to 16 bits : 0.
  - acc <= sum_out; cnt <= cnt+1.
  - When cnt == WIDTH-1, go to XFER.
- XFER:
  - sum_in_a = sum_in_b = 0.
  - mcand <= acc; acc <= 0; cnt <= 0; go to P2.
- P2 (a*a*a):
  - Same datapath as P1.
  - When cnt == WIDTH-1: result <= sum_out; go to IDLE.
- Timing: with start accepted at edge 0, busy is high for 2*WIDTH+1 cycles (11 at the default WIDTH). result updates on the same edge that busy falls.
- result holds its last value through the next run until that run's final P2 edge. It is never cleared by start.
- start while busy is ignored; a_i changes while busy are ignored.
- start held high continuously restarts on the IDLE cycle after each completion, with one IDLE cycle between runs.
- a_i=0: run length is unchanged; result=0.
- Every adder request is exactly the two operand buses. No state reads sum_out unless that state drives the operands.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=0, P1=1, XFER=2, P2=3;
  - SUM_W=16, the adder width;
  - MAX_CUBE_W=5.
- The shift-add pass (P1/P2 datapath) is a natural sub-module, sa_pass. It has mcand/multiplier/cnt inputs and drives the adder operands.
- Keeping the pass inline is acceptable: the block stays under about 200 lines either way.

Test Plan:
1. Reset low mid-P1 with a_i=7, then release: busy=0 and result=0 immediately; the next start a_i=2 gives result=8.
2. start with a_i=3: busy high exactly 11 cycles; result=27 on the falling edge of busy.
3. a_i=31 gives 29791. a_i=0 gives 0 after the full 11 cycles. a_i=1 gives 1.
4. Adder traffic for a_i=5: in P1, sum_in_b is nonzero only at cnt=0 (5) and cnt=2 (20). At XFER, mcand=25. In P2, sum_in_b is 25 then 100, and the final sum is 125.
5. Pulse start with a_i=4 during a run with a_i=2: the second pulse is ignored and result=8. With start held high and a_i=3, back-to-back runs each give 27 with a one-cycle busy gap.
6. Round-trip sweep against a reference adder model: for a in 0..31, result == a^3. For WIDTH=3, all 8 values, with busy length 7.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared definitions for the iterative cube block.
// State encoding and shared adder geometry.
package cube_pkg;
  localparam int SUM_W      = 16;
  localparam int MAX_CUBE_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    XFER = 2'd2,
    P2   = 2'd3
  } state_t;
endpackage

// File: rtl/cube_sa_pass.sv
// Shift-add pass: one multiplier bit per cycle,
// presented to the shared adder as two operands.
module cube_sa_pass
  import cube_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CW    = 4
) (
  input  logic             en,
  input  logic [SUM_W-1:0] acc,
  input  logic [SUM_W-1:0] mcand,
  input  logic [WIDTH-1:0] mult,
  input  logic [CW-1:0]    cnt,
  output logic [SUM_W-1:0] sum_in_a,
  output logic [SUM_W-1:0] sum_in_b
);
  logic [WIDTH-1:0] sh;

  assign sh = mult >> cnt;

  always_comb begin
    sum_in_a = '0;
    sum_in_b = '0;
    if (en) begin
      sum_in_a = acc;
      if (sh[0]) sum_in_b = mcand << cnt;
    end
  end
endmodule

// File: rtl/cube.sv
// Iterative integer cube y = a^3 using an external
// shared 16-bit adder for every wide addition.
module cube
  import cube_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int RES_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_i,
  input  logic             start,
  output logic [RES_W-1:0] result,
  output logic             busy,
  output logic [SUM_W-1:0] sum_in_a,
  output logic [SUM_W-1:0] sum_in_b,
  input  logic [SUM_W-1:0] sum_out
);
  localparam int CW = $clog2(WIDTH) + 1;

  if (WIDTH < 1 || WIDTH > MAX_CUBE_W) begin : g_bad_width
    $error("cube: WIDTH must be 1..5");
  end
  if (RES_W != SUM_W) begin : g_bad_res
    $error("cube: RES_W must equal SUM_W");
  end

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] mcand;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             en;

  assign busy = (state != IDLE);
  assign en   = (state == P1) || (state == P2);
  assign last = (cnt == CW'(WIDTH - 1));

  cube_sa_pass #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_pass (
    .en      (en),
    .acc     (acc),
    .mcand   (mcand),
    .mult    (a),
    .cnt     (cnt),
    .sum_in_a(sum_in_a),
    .sum_in_b(sum_in_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      a      <= '0;
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a     <= a_i;
            mcand <= SUM_W'(a_i);
            acc   <= '0;
            cnt   <= '0;
            state <= P1;
          end
        end
        P1: begin
          acc <= sum_out;
          cnt <= cnt + CW'(1);
          if (last) state <= XFER;
        end
        XFER: begin
          // a*a becomes the multiplicand for the second pass
          mcand <= acc;
          acc   <= '0;
          cnt   <= '0;
          state <= P2;
        end
        P2: begin
          acc <= sum_out;
          cnt <= cnt + CW'(1);
          if (last) begin
            result <= sum_out;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cube.sv
// Self-checking bench for cube at WIDTH=5 and WIDTH=3,
// each instance paired with its own shared-adder model.
module tb_cube;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  a_i;
  logic        start;
  logic [15:0] result;
  logic        busy;
  logic [15:0] sa, sb, so;

  logic [2:0]  a3;
  logic        start3;
  logic [15:0] result3;
  logic        busy3;
  logic [15:0] sa3, sb3, so3;

  int n_chk  = 0;
  int n_fail = 0;
  int exp5   = 0;
  int exp3   = 0;

  always #5 clk = ~clk;

  assign so  = sa + sb;
  assign so3 = sa3 + sb3;

  cube #(.WIDTH(5), .RES_W(16)) dut5 (
    .clk     (clk),
    .rst     (rst),
    .a_i     (a_i),
    .start   (start),
    .result  (result),
    .busy    (busy),
    .sum_in_a(sa),
    .sum_in_b(sb),
    .sum_out (so)
  );

  cube #(.WIDTH(3), .RES_W(16)) dut3 (
    .clk     (clk),
    .rst     (rst),
    .a_i     (a3),
    .start   (start3),
    .result  (result3),
    .busy    (busy3),
    .sum_in_a(sa3),
    .sum_in_b(sb3),
    .sum_out (so3)
  );

  function automatic int cube_ref(input int v);
    return (v * v * v) % 65536;
  endfunction

  // Operand B expected k cycles after start is accepted:
  // pass one multiplies v by v, pass two multiplies v*v by v.
  function automatic int trace_b(input int v, input int k, input int w);
    int m, j;
    if (k == w) return 0;
    m = (k < w) ? v : v * v;
    j = (k < w) ? k : k - w - 1;
    if (((v >> j) & 1) == 1) return (m * (1 << j)) % 65536;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run5(input int v);
    int blen;
    @(negedge clk);
    a_i   = 5'(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    blen  = 0;
    while (busy === 1'b1 && blen < 64) begin
      chk("hold5", result, exp5);
      a_i = 5'($urandom);
      blen++;
      @(posedge clk); #1;
    end
    exp5 = cube_ref(v);
    chk("len5", blen, 11);
    chk("res5", result, exp5);
  endtask

  task automatic run3(input int v);
    int blen;
    @(negedge clk);
    a3     = 3'(v);
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    blen   = 0;
    while (busy3 === 1'b1 && blen < 64) begin
      chk("hold3", result3, exp3);
      a3 = 3'($urandom);
      blen++;
      @(posedge clk); #1;
    end
    exp3 = cube_ref(v);
    chk("len3", blen, 7);
    chk("res3", result3, exp3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int blen;
    rst    = 1'b0;
    start  = 1'b0;
    a_i    = '0;
    start3 = 1'b0;
    a3     = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_res", result, 0);
    chk("rst_sa", sa, 0);
    chk("rst_sb", sb, 0);
    chk("rst_busy3", busy3, 0);
    @(negedge clk);
    rst = 1'b1;

    // Baseline run, then abort a run mid-first-pass
    run5(3);
    @(negedge clk);
    a_i   = 5'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_res", result, 0);
    chk("abort_sa", sa, 0);
    chk("abort_sb", sb, 0);
    exp5 = 0;
    exp3 = 0;
    @(negedge clk);
    rst = 1'b1;
    run5(2);

    // Edge operands
    run5(31);
    run5(0);
    run5(1);

    // Adder traffic for a=5
    @(negedge clk);
    a_i   = 5'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      chk("tr_busy", busy, 1);
      chk("tr_b", sb, trace_b(5, k, 5));
      if (k == 10) chk("tr_sum", so, 125);
      @(posedge clk); #1;
    end
    chk("tr_end", busy, 0);
    chk("tr_res", result, 125);
    exp5 = 125;

    // Second start pulse while busy is ignored
    @(negedge clk);
    a_i   = 5'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    blen  = 0;
    while (busy === 1'b1 && blen < 64) begin
      if (blen == 3) begin
        start = 1'b1;
        a_i   = 5'd4;
      end else begin
        start = 1'b0;
      end
      blen++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("pulse_len", blen, 11);
    chk("pulse_res", result, 8);
    @(posedge clk); #1;
    chk("pulse_idle", busy, 0);
    exp5 = 8;

    // start held high: back-to-back runs, one idle cycle apart
    @(negedge clk);
    a_i   = 5'd3;
    start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 24; i++) begin
      chk("held_busy", busy, ((i % 12) != 11) ? 1 : 0);
      if ((i % 12) == 11) chk("held_res", result, 27);
      if (i == 23) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("held_stop", busy, 0);
    exp5 = 27;

    // Full sweep, then random operands
    for (int v = 0; v < 32; v++) run5(v);
    for (int r = 0; r < 20; r++) run5(int'($urandom_range(0, 31)));

    // Narrow instance: all operands
    for (int v = 0; v < 8; v++) run3(v);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
